// File: rtl/mean_port_pkg.sv
// rtl/mean_port_pkg.sv - shared default widths and segment constants for the mean-sample port FIFO
package mean_port_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int SEG_LEN_DEF  = 42;
  localparam int KEEP_LEN_DEF = 40;
  localparam int ADDR_W_DEF   = 6;
  localparam int AF_TH_DEF    = 56;

endpackage

// File: rtl/async_fifo_gray.sv
// rtl/async_fifo_gray.sv - dual-clock FIFO with Gray-coded pointers, 2-flop synchronisers and write-side level
module async_fifo_gray
  import mean_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AF_TH  = AF_TH_DEF
) (
  input  logic              wr_clk_i,
  input  logic              wr_rst_n_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   wr_level_o,
  input  logic              rd_clk_i,
  input  logic              rd_rst_n_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              empty_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d, wgray_q;
  logic [PW-1:0] rq1_q, rq2_q, rq2_bin;
  logic [PW-1:0] rbin_q, rbin_d, rgray_q;
  logic [PW-1:0] wq1_q, wq2_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              push, pop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // write-side occupancy against the synchronised read pointer; flags follow from it
  assign rq2_bin       = gray2bin(rq2_q);
  assign wr_level_o    = wbin_q - rq2_bin;
  assign full_o        = (wr_level_o == PW'(DEPTH));
  assign almost_full_o = (wr_level_o >= PW'(AF_TH));
  assign push          = wr_en_i && !full_o;
  assign wbin_d        = push ? wbin_q + PW'(1) : wbin_q;

  // write pointer in binary and Gray, plus read-pointer synchroniser
  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wbin_d ^ (wbin_d >> 1);
      rq1_q   <= rgray_q;
      rq2_q   <= rq1_q;
    end
  end

  // storage array written in the write domain, no reset so it maps onto block RAM
  always_ff @(posedge wr_clk_i) begin
    if (push) begin
      mem_q[wbin_q[ADDR_W-1:0]] <= wr_data_i;
    end
  end

  assign empty_o = (rgray_q == wq2_q);
  assign pop     = rd_en_i && !empty_o;
  assign rbin_d  = pop ? rbin_q + PW'(1) : rbin_q;

  // read pointer, write-pointer synchroniser and registered read data
  always_ff @(posedge rd_clk_i or negedge rd_rst_n_i) begin
    if (!rd_rst_n_i) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      wq1_q      <= '0;
      wq2_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rbin_d ^ (rbin_d >> 1);
      wq1_q      <= wgray_q;
      wq2_q      <= wq1_q;
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem_q[rbin_q[ADDR_W-1:0]];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/mean_port_fifo.sv
// rtl/mean_port_fifo.sv - segment-gated capture of zone means into a dual-clock FIFO with sticky overflow
module mean_port_fifo
  import mean_port_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEG_LEN  = SEG_LEN_DEF,
  parameter int KEEP_LEN = KEEP_LEN_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_TH    = AF_TH_DEF
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              rd_clk,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              ovf_clr,
  input  logic              rd_start,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              ovf
);

  localparam int CNT_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

  logic [1:0]        wr_rst_q, rd_rst_q;
  logic              wr_rst_n, rd_rst_n;
  logic [CNT_W-1:0]  seg_cnt_q, seg_cnt_d;
  logic              keep;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              ovf_q, ovf_d;
  logic              drop;

  // reset asserts at once, releases two write clocks later
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) wr_rst_q <= 2'b00;
    else        wr_rst_q <= {wr_rst_q[0], 1'b1};
  end

  // reset asserts at once, releases two read clocks later
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) rd_rst_q <= 2'b00;
    else        rd_rst_q <= {rd_rst_q[0], 1'b1};
  end

  assign wr_rst_n = wr_rst_q[1];
  assign rd_rst_n = rd_rst_q[1];

  // next segment count: wraps after SEG_LEN-1 and restarts whenever data_valid drops
  always_comb begin
    seg_cnt_d = '0;
    if (data_valid && (int'(seg_cnt_q) != SEG_LEN - 1)) begin
      seg_cnt_d = seg_cnt_q + CNT_W'(1);
    end
  end

  assign keep = data_valid && (int'(seg_cnt_q) < KEEP_LEN);

  // segment counter and the write register that keeps data and strobe aligned
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      seg_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      seg_cnt_q <= seg_cnt_d;
      wr_en_q   <= keep;
      if (keep) begin
        wr_data_q <= din;
      end
    end
  end

  // a drop in the same cycle as a clear leaves the flag set
  assign drop = wr_en_q && full;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // sticky overflow flag
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) ovf_q <= 1'b0;
    else           ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

  async_fifo_gray #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .AF_TH  (AF_TH)
  ) u_fifo (
    .wr_clk_i      (wr_clk),
    .wr_rst_n_i    (wr_rst_n),
    .wr_en_i       (wr_en_q),
    .wr_data_i     (wr_data_q),
    .full_o        (full),
    .almost_full_o (almost_full),
    .wr_level_o    (wr_level),
    .rd_clk_i      (rd_clk),
    .rd_rst_n_i    (rd_rst_n),
    .rd_en_i       (rd_start),
    .rd_data_o     (dout),
    .rd_valid_o    (dout_valid),
    .empty_o       (empty)
  );

endmodule

// File: tb/tb_mean_port_fifo.sv
// tb/tb_mean_port_fifo.sv - self-checking bench for mean_port_fifo
`timescale 1ns/100ps
module tb_mean_port_fifo;

  localparam int DW    = 8;
  localparam int SEG   = 42;
  localparam int KEEP  = 40;
  localparam int AW    = 6;
  localparam int AFT   = 56;
  localparam int DEPTH = 64;
  localparam int MSZ   = 8192;

  logic          wr_clk = 1'b0;
  logic          rd_clk = 1'b0;
  logic          rst_n;
  logic          data_valid;
  logic [DW-1:0] din;
  logic          ovf_clr;
  logic          rd_start = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          ovf;

  mean_port_fifo #(
    .DATA_W   (DW),
    .SEG_LEN  (SEG),
    .KEEP_LEN (KEEP),
    .ADDR_W   (AW),
    .AF_TH    (AFT)
  ) dut (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .rd_clk      (rd_clk),
    .data_valid  (data_valid),
    .din         (din),
    .ovf_clr     (ovf_clr),
    .rd_start    (rd_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .ovf         (ovf)
  );

  // 100 MHz write clock, ~37 MHz read clock with a phase offset
  always #5 wr_clk = ~wr_clk;
  initial begin
    #3;
    forever #13.5 rd_clk = ~rd_clk;
  end

  // model state: expected stream of accepted words, indexed by write and read counts
  logic [DW-1:0] exp_mem [MSZ];
  int            wr_idx = 0;
  int            rd_idx = 0;
  int            n_pops = 0;
  logic          m_ovf = 1'b0;
  bit            check_level = 1'b0;
  int            rd_mode = 0;
  int            val = 0;

  int n_chk_w = 0, n_err_w = 0;
  int n_chk_r = 0, n_err_r = 0;
  int n_chk_i = 0, n_err_i = 0;

  // write-side model: beat index within each data_valid run decides keep; push lands next cycle
  initial begin
    int       run_len;
    logic     pend;
    logic [DW-1:0] pend_data;
    logic     drop;
    run_len = 0;
    pend = 1'b0;
    pend_data = '0;
    forever begin
      @(posedge wr_clk or negedge rst_n);
      if (!rst_n) begin
        run_len = 0;
        pend    = 1'b0;
        wr_idx  = 0;
        m_ovf   = 1'b0;
      end else begin
        drop = 1'b0;
        if (pend) begin
          if (wr_idx - rd_idx >= DEPTH) drop = 1'b1;
          else begin
            exp_mem[wr_idx % MSZ] = pend_data;
            wr_idx++;
          end
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        pend = 1'b0;
        if (data_valid) begin
          if ((run_len % SEG) < KEEP) begin
            pend      = 1'b1;
            pend_data = din;
          end
          run_len++;
        end else begin
          run_len = 0;
        end
      end
    end
  end

  // write-side compare: ovf always, level and flags while reads are quiesced
  initial begin
    int          occ;
    logic [AW:0] exp_lvl;
    forever begin
      @(negedge wr_clk);
      if (rst_n) begin
        n_chk_w++;
        if (ovf !== m_ovf) begin
          n_err_w++;
          $display("FAIL ovf_track t=%0t got %b expected %b", $time, ovf, m_ovf);
        end
        if (check_level) begin
          occ     = wr_idx - rd_idx;
          exp_lvl = occ[AW:0];
          n_chk_w++;
          if (wr_level !== exp_lvl) begin
            n_err_w++;
            $display("FAIL wr_level_track t=%0t got %0d expected %0d", $time, wr_level, exp_lvl);
          end
          n_chk_w++;
          if (full !== (occ >= DEPTH)) begin
            n_err_w++;
            $display("FAIL full_track t=%0t got %b expected %b", $time, full, (occ >= DEPTH));
          end
          n_chk_w++;
          if (almost_full !== (occ >= AFT)) begin
            n_err_w++;
            $display("FAIL almost_full_track t=%0t got %b expected %b", $time, almost_full, (occ >= AFT));
          end
        end
      end
    end
  end

  // read-side compare: every dout_valid pulse must carry the next accepted word
  initial begin
    forever begin
      @(negedge rd_clk);
      if (!rst_n) begin
        rd_idx = 0;
      end else if (dout_valid) begin
        n_pops++;
        n_chk_r++;
        if (rd_idx >= wr_idx) begin
          n_err_r++;
          $display("FAIL pop_underflow t=%0t got dout %0d expected no pop", $time, dout);
        end else begin
          if (dout !== exp_mem[rd_idx % MSZ]) begin
            n_err_r++;
            $display("FAIL dout_order t=%0t got %0d expected %0d", $time, dout, exp_mem[rd_idx % MSZ]);
          end
          rd_idx++;
        end
      end
    end
  end

  // read request driver: 0 idle, 1 held high, 2 random
  initial begin
    forever begin
      @(negedge rd_clk);
      case (rd_mode)
        1:       rd_start = 1'b1;
        2:       rd_start = 1'($urandom_range(0, 1));
        default: rd_start = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_chk_i++;
    if (got != exp) begin
      n_err_i++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic send_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge wr_clk);
      data_valid = 1'b1;
      din        = val[DW-1:0];
      val++;
    end
    @(negedge wr_clk);
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wr_clk);
  endtask

  task automatic drain();
    int i;
    check_level = 1'b0;
    rd_mode = 1;
    i = 0;
    while (i < 400 && rd_idx != wr_idx) begin
      @(negedge rd_clk);
      i++;
    end
    check("drain_complete", rd_idx, wr_idx);
    rd_mode = 0;
    repeat (6) @(negedge rd_clk);
    check("empty_after_drain", int'(empty), 1);
  endtask

  initial begin
    int p0, w0, b;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    din        = '0;
    ovf_clr    = 1'b0;

    // reset values
    idle(4);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_almost_full", int'(almost_full), 0);
    check("rst_wr_level", int'(wr_level), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    rst_n = 1'b1;
    idle(5);

    // one full segment, reads idle: 40 of 42 kept
    check_level = 1'b1;
    w0 = wr_idx; b = val;
    send_run(42);
    idle(10);
    check("seg_wr_level", int'(wr_level), 40);
    check("seg_model_kept", wr_idx - w0, 40);
    check("seg_model_last", int'(exp_mem[(w0 + 39) % MSZ]), (b + 39) % 256);
    check("seg_not_empty", int'(empty), 0);
    p0 = n_pops;
    drain();
    check("seg_pops", n_pops - p0, 40);
    check("seg_last_dout", int'(dout), (b + 39) % 256);

    // 11 beats, one idle cycle, 35 beats: counter restarts, all 46 kept
    check_level = 1'b1;
    w0 = wr_idx;
    send_run(11);
    send_run(35);
    idle(4);
    check("restart_wr_level", int'(wr_level), 46);
    check("restart_model_kept", wr_idx - w0, 46);
    p0 = n_pops;
    drain();
    check("restart_pops", n_pops - p0, 46);

    // 66 kept beats into 64 slots: full, almost_full, ovf, then clear
    check_level = 1'b1;
    w0 = wr_idx; b = val;
    send_run(40);
    send_run(26);
    idle(4);
    check("ovfl_wr_level", int'(wr_level), 64);
    check("ovfl_full", int'(full), 1);
    check("ovfl_almost_full", int'(almost_full), 1);
    check("ovfl_ovf", int'(ovf), 1);
    check("ovfl_model_kept", wr_idx - w0, 64);
    @(negedge wr_clk);
    ovf_clr = 1'b1;
    @(negedge wr_clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", int'(ovf), 0);
    p0 = n_pops;
    drain();
    check("ovfl_pops", n_pops - p0, 64);
    check("ovfl_last_dout", int'(dout), (b + 63) % 256);

    // three segments with reads held high
    p0 = n_pops; w0 = wr_idx;
    rd_mode = 1;
    for (int s = 0; s < 3; s++) begin
      send_run(42);
      idle(200);
    end
    drain();
    check("stream_pops", n_pops - p0, 120);
    check("stream_model_kept", wr_idx - w0, 120);

    // reset mid-segment with 20 words stored
    check_level = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge wr_clk);
      data_valid = 1'b1;
      din        = val[DW-1:0];
      val++;
    end
    @(negedge wr_clk);
    check("pre_rst_wr_level", int'(wr_level), 20);
    check_level = 1'b0;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    idle(10);
    check("midrst_empty", int'(empty), 1);
    check("midrst_wr_level", int'(wr_level), 0);
    check("midrst_dout_valid", int'(dout_valid), 0);
    rst_n = 1'b1;
    idle(5);
    check_level = 1'b1;
    b = val;
    send_run(42);
    idle(4);
    check("postrst_wr_level", int'(wr_level), 40);
    check("postrst_model_first", int'(exp_mem[0]), b % 256);
    p0 = n_pops;
    drain();
    check("postrst_pops", n_pops - p0, 40);

    // random run lengths with random read requests
    rd_mode = 2;
    for (int s = 0; s < 30; s++) begin
      send_run(int'($urandom_range(1, 60)));
      idle(400);
    end
    drain();
    check("random_ovf", int'(ovf), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk_w + n_chk_r + n_chk_i, n_err_w + n_err_r + n_err_i);
    $finish;
  end

endmodule
